gfx_transform_sequencer: RTL and testbench

//  Front-end controller for the transform unit. Accepts a stream of primitive

---
 rtl/gfx_transform_sequencer.sv | 147 ++++++++++++++
 tb/tb_gfx_transform_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_transform_sequencer.sv
// Front-end sequencer for the transform unit: issues primitive vertices one point
// at a time, waits for the unit's ack, then offers the finished primitive downstream.
module gfx_transform_sequencer #(
  parameter int point_width    = 16,
  parameter int subpixel_width = 16,
  parameter int timeout_cycles = 15,
  parameter int timer_width    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  pt_valid_i,
  output logic                                  pt_ready_o,
  input  logic [point_width+subpixel_width-1:0] pt_x_i,
  input  logic [point_width+subpixel_width-1:0] pt_y_i,
  input  logic [point_width+subpixel_width-1:0] pt_z_i,
  input  logic [1:0]                            pt_count_i,
  input  logic                                  transform_en_i,
  output logic [point_width+subpixel_width-1:0] xf_x_o,
  output logic [point_width+subpixel_width-1:0] xf_y_o,
  output logic [point_width+subpixel_width-1:0] xf_z_o,
  output logic [1:0]                            xf_point_id_o,
  output logic                                  xf_transform_o,
  output logic                                  xf_forward_o,
  input  logic                                  xf_ack_i,
  output logic                                  prim_valid_o,
  input  logic                                  prim_ready_i,
  output logic                                  busy_o,
  output logic                                  timeout_o
);

  localparam int cw = point_width + subpixel_width;
  localparam bit timeout_en = (timeout_cycles != 0);
  localparam logic [timer_width-1:0] timer_last =
    timer_width'((timeout_cycles > 0) ? (timeout_cycles - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [1:0]             idx_r;
  logic [1:0]             count_r;
  logic                   mode_r;
  logic [timer_width-1:0] timer_r;

  logic accept_s;
  logic expire_s;
  logic advance_s;
  logic last_s;

  assign accept_s  = pt_valid_i & pt_ready_o;
  assign expire_s  = timeout_en && (timer_r == timer_last);
  assign advance_s = xf_ack_i | expire_s;
  assign last_s    = (idx_r == (count_r - 2'd1));

  // Sequencer FSM; strobes are launched on entry to ISSUE so every output stays registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= ST_IDLE;
      idx_r          <= 2'd0;
      count_r        <= 2'd0;
      mode_r         <= 1'b0;
      timer_r        <= '0;
      pt_ready_o     <= 1'b1;
      xf_x_o         <= {cw{1'b0}};
      xf_y_o         <= {cw{1'b0}};
      xf_z_o         <= {cw{1'b0}};
      xf_point_id_o  <= 2'd0;
      xf_transform_o <= 1'b0;
      xf_forward_o   <= 1'b0;
      prim_valid_o   <= 1'b0;
      busy_o         <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            xf_x_o        <= pt_x_i;
            xf_y_o        <= pt_y_i;
            xf_z_o        <= pt_z_i;
            xf_point_id_o <= idx_r;
            if (idx_r == 2'd0) begin
              count_r        <= (pt_count_i == 2'd0) ? 2'd3 : pt_count_i;
              mode_r         <= transform_en_i;
              timeout_o      <= 1'b0;
              xf_transform_o <= transform_en_i;
              xf_forward_o   <= ~transform_en_i;
            end else begin
              xf_transform_o <= mode_r;
              xf_forward_o   <= ~mode_r;
            end
            pt_ready_o <= 1'b0;
            busy_o     <= 1'b1;
            state_r    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          xf_transform_o <= 1'b0;
          xf_forward_o   <= 1'b0;
          timer_r        <= '0;
          state_r        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (advance_s) begin
            timer_r <= '0;
            // a missing ack is treated as an ack, but remembered for this primitive
            if (!xf_ack_i) begin
              timeout_o <= 1'b1;
            end
            if (last_s) begin
              prim_valid_o <= 1'b1;
              state_r      <= ST_DONE;
            end else begin
              idx_r      <= idx_r + 2'd1;
              pt_ready_o <= 1'b1;
              state_r    <= ST_IDLE;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        ST_DONE: begin
          if (prim_ready_i) begin
            prim_valid_o <= 1'b0;
            idx_r        <= 2'd0;
            pt_ready_o   <= 1'b1;
            busy_o       <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          idx_r          <= 2'd0;
          pt_ready_o     <= 1'b1;
          xf_transform_o <= 1'b0;
          xf_forward_o   <= 1'b0;
          prim_valid_o   <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_transform_sequencer.sv
// Bench for gfx_transform_sequencer: directed and randomized primitives checked
// against a transaction-level model of the issue / ack / handshake protocol.
module tb_gfx_transform_sequencer;

  localparam int W  = 32;
  localparam int TO = 15;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         pt_valid_i = 1'b0;
  logic         pt_ready_o;
  logic [W-1:0] pt_x_i = '0, pt_y_i = '0, pt_z_i = '0;
  logic [1:0]   pt_count_i = 2'd0;
  logic         transform_en_i = 1'b0;
  logic [W-1:0] xf_x_o, xf_y_o, xf_z_o;
  logic [1:0]   xf_point_id_o;
  logic         xf_transform_o, xf_forward_o;
  logic         xf_ack_i = 1'b0;
  logic         prim_valid_o;
  logic         prim_ready_i = 1'b0;
  logic         busy_o, timeout_o;

  gfx_transform_sequencer #(
    .point_width(16), .subpixel_width(16), .timeout_cycles(TO), .timer_width(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o),
    .pt_x_i(pt_x_i), .pt_y_i(pt_y_i), .pt_z_i(pt_z_i),
    .pt_count_i(pt_count_i), .transform_en_i(transform_en_i),
    .xf_x_o(xf_x_o), .xf_y_o(xf_y_o), .xf_z_o(xf_z_o),
    .xf_point_id_o(xf_point_id_o),
    .xf_transform_o(xf_transform_o), .xf_forward_o(xf_forward_o),
    .xf_ack_i(xf_ack_i),
    .prim_valid_o(prim_valid_o), .prim_ready_i(prim_ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // primitive description for the model
  logic [W-1:0] px [3];
  logic [W-1:0] py [3];
  logic [W-1:0] pz [3];
  int           dly [3];   // ack delay in cycles after the strobe; 0 = never ack
  bit           exp_to = 1'b0;
  int           last_lat = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_prim(input logic [1:0] cnt_code, input bit mode, input int hold_cyc);
    int n;
    int t0;
    int lat_exp;
    int d;
    int waits;
    bit acc;
    logic [1:0] idv;
    n = (cnt_code == 2'd0) ? 3 : int'(cnt_code);
    t0 = 0;
    lat_exp = 0;
    for (int i = 0; i < n; i++) begin
      idv = 2'(i);
      pt_valid_i     = 1'b1;
      pt_x_i         = px[i];
      pt_y_i         = py[i];
      pt_z_i         = pz[i];
      pt_count_i     = (i == 0) ? cnt_code : 2'($urandom);
      transform_en_i = (i == 0) ? mode : 1'($urandom);
      acc = 1'b0;
      waits = 0;
      for (int k = 0; k < 40 && !acc; k++) begin
        acc = pt_ready_o;
        step();
        if (!acc) waits++;
      end
      check("accept_wait", 64'(waits), 64'd0);
      if (!acc) return;
      if (i == 0) begin
        t0 = cyc;
        exp_to = 1'b0;
      end
      check("strobe", {xf_transform_o, xf_forward_o}, {mode, ~mode});
      check("xf_x", xf_x_o, px[i]);
      check("xf_y", xf_y_o, py[i]);
      check("xf_z", xf_z_o, pz[i]);
      check("xf_id", xf_point_id_o, idv);
      check("issue_flags", {pt_ready_o, prim_valid_o, busy_o, timeout_o}, {3'b001, exp_to});
      // junk on the vertex bus and a stray ack while the strobe is out
      if ($urandom_range(0, 1) == 1) begin
        pt_x_i = $urandom;
        pt_y_i = $urandom;
      end else begin
        pt_valid_i = 1'b0;
      end
      xf_ack_i = 1'($urandom_range(0, 1));
      step();
      xf_ack_i = 1'b0;
      check("hold_wait0", {pt_ready_o, prim_valid_o, xf_transform_o, xf_forward_o, xf_point_id_o, xf_x_o},
            {4'b0000, idv, px[i]});
      d = dly[i];
      if (d == 0) begin
        for (int k = 1; k < TO; k++) begin
          step();
          check("hold_to", {pt_ready_o, prim_valid_o, xf_transform_o, xf_forward_o, xf_point_id_o, xf_x_o},
                {4'b0000, idv, px[i]});
        end
        step();
        exp_to = 1'b1;
        d = TO;
      end else begin
        for (int k = 1; k < d; k++) begin
          step();
          check("hold_ack", {pt_ready_o, prim_valid_o, xf_transform_o, xf_forward_o, xf_point_id_o, xf_x_o},
                {4'b0000, idv, px[i]});
        end
        xf_ack_i = 1'b1;
        step();
        xf_ack_i = 1'b0;
      end
      check("timeout_flag", timeout_o, exp_to);
      if (i == n - 1) begin
        last_lat = cyc - t0;
        check("done_entry", {prim_valid_o, pt_ready_o, busy_o}, 3'b101);
        check("latency", 64'(last_lat), 64'(lat_exp + d + 1));
      end else begin
        lat_exp += d + 2;
        check("next_ready", {prim_valid_o, pt_ready_o, busy_o}, 3'b011);
      end
    end
    // DONE: downstream stalls, a vertex waits, stray acks must be ignored
    pt_valid_i = 1'b1;
    pt_x_i = $urandom;
    prim_ready_i = 1'b0;
    for (int k = 0; k < hold_cyc; k++) begin
      xf_ack_i = 1'($urandom_range(0, 1));
      step();
      check("done_hold", {prim_valid_o, pt_ready_o, xf_transform_o, xf_forward_o}, 4'b1000);
    end
    xf_ack_i = 1'b0;
    prim_ready_i = 1'b1;
    step();
    prim_ready_i = 1'b0;
    pt_valid_i = 1'b0;
    check("handshake", {prim_valid_o, pt_ready_o, busy_o, timeout_o}, {3'b010, exp_to});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("reset", {pt_ready_o, xf_transform_o, xf_forward_o, prim_valid_o, busy_o, timeout_o}, 6'b100000);
    check("reset_id", xf_point_id_o, 2'd0);

    // 2: three transformed points (1.0, 2.0, 3.0), ack two cycles after each strobe
    for (int i = 0; i < 3; i++) begin
      px[i] = 32'h0001_0000;
      py[i] = 32'h0002_0000;
      pz[i] = 32'h0003_0000;
      dly[i] = 2;
    end
    run_prim(2'd3, 1'b1, 0);
    check("lat_3pt", 64'(last_lat), 64'd11);

    // 3: single forwarded point, slow ack
    px[0] = 32'h0005_0000;
    py[0] = 32'hFFFF_8000;
    pz[0] = 32'h0000_0001;
    dly[0] = 4;
    run_prim(2'd1, 1'b0, 2);

    // 4: long rasteriser stall with a vertex waiting
    for (int i = 0; i < 3; i++) begin
      px[i] = $urandom; py[i] = $urandom; pz[i] = $urandom; dly[i] = 2;
    end
    run_prim(2'd2, 1'b1, 20);

    // 5: first point never acked -> forced advance, flag sticks through the primitive
    for (int i = 0; i < 3; i++) begin
      px[i] = $urandom; py[i] = $urandom; pz[i] = $urandom;
    end
    dly[0] = 0;
    dly[1] = 3;
    run_prim(2'd2, 1'b0, 1);
    dly[0] = 1;
    run_prim(2'd1, 1'b1, 0);

    // 6: reset while point 1 waits for its ack, then a stray ack in IDLE
    pt_valid_i = 1'b1;
    pt_count_i = 2'd3;
    transform_en_i = 1'b1;
    pt_x_i = 32'h1234_5678;
    step();
    pt_valid_i = 1'b0;
    step();
    xf_ack_i = 1'b1;
    step();
    xf_ack_i = 1'b0;
    check("mid_idle", {pt_ready_o, busy_o}, 2'b11);
    pt_valid_i = 1'b1;
    step();
    pt_valid_i = 1'b0;
    check("mid_id1", xf_point_id_o, 2'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_reset", {pt_ready_o, busy_o, xf_transform_o, xf_forward_o, prim_valid_o, timeout_o}, 6'b100000);
    xf_ack_i = 1'b1;
    step();
    xf_ack_i = 1'b0;
    check("stray_ack", {pt_ready_o, busy_o, xf_transform_o, xf_forward_o, prim_valid_o}, 5'b10000);
    px[0] = $urandom; py[0] = $urandom; pz[0] = $urandom; dly[0] = 2;
    run_prim(2'd1, 1'b1, 0);

    // randomized primitives
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 3; i++) begin
        px[i] = $urandom;
        py[i] = $urandom;
        pz[i] = $urandom;
        dly[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      end
      run_prim(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
